// File: rtl/fetch_pc_btb.sv
// Fetch program counter with a direct-mapped branch target buffer.
// Each cycle the registered pc indexes the BTB combinationally; the next pc is
// chosen from reset, redirect, stall, predicted target or the fall-through.
// Resolved branches train the BTB with 2-bit saturating counters.
module fetch_pc_btb #(
    parameter int unsigned          WordSize    = 32,
    parameter int unsigned          BtbEntries  = 16,
    parameter logic [WordSize-1:0]  ResetVector = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [WordSize-1:0] i_redirect_pc,
    input  logic                i_upd_en,
    input  logic [WordSize-1:0] i_upd_pc,
    input  logic [WordSize-1:0] i_upd_target,
    input  logic                i_upd_taken,
    output logic [WordSize-1:0] o_pc,
    output logic                o_pred_taken,
    output logic [WordSize-1:0] o_pred_addr,
    output logic [WordSize-1:0] o_pred_pc
);

    localparam int unsigned IdxBits = $clog2(BtbEntries);
    localparam int unsigned TagBits = WordSize - IdxBits - 2;

    // Word-aligned reset address; the low two bits of the parameter are dropped.
    localparam logic [WordSize-1:0] ResetPc = {ResetVector[WordSize-1:2], 2'b00};

    // Saturating counter encodings used on allocation and reset.
    localparam logic [1:0] CtrAlloc = 2'b10;
    localparam logic [1:0] CtrReset = 2'b01;
    localparam logic [1:0] CtrMax   = 2'b11;
    localparam logic [1:0] CtrMin   = 2'b00;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WordSize-1:0] r_pc;

    logic [BtbEntries-1:0] r_valid;
    logic [TagBits-1:0]    r_tag    [BtbEntries];
    logic [WordSize-1:0]   r_target [BtbEntries];
    logic [1:0]            r_ctr    [BtbEntries];

    // ------------------------------------------------------------------
    // Lookup side
    // ------------------------------------------------------------------
    logic [IdxBits-1:0]  w_idx;
    logic [TagBits-1:0]  w_tag;
    logic                w_hit;
    logic                w_pred_taken;
    logic [WordSize-1:0] w_pred_addr;
    logic [WordSize-1:0] w_pred_pc;
    logic [WordSize-1:0] w_pc_next;

    assign w_idx = r_pc[IdxBits+1:2];
    assign w_tag = r_pc[WordSize-1:IdxBits+2];

    // Combinational BTB lookup from the registered pc and current table contents.
    always_comb begin
        w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
        w_pred_taken = w_hit && r_ctr[w_idx][1];
        w_pred_addr  = '0;
        if (w_pred_taken) begin
            w_pred_addr = r_target[w_idx];
        end
        // Wraps naturally modulo 2^WordSize.
        w_pred_pc    = r_pc + WordSize'(4);
    end

    // Next-pc priority: redirect over stall over prediction over fall-through.
    always_comb begin
        w_pc_next = w_pred_pc;
        if (i_redirect) begin
            w_pc_next = {i_redirect_pc[WordSize-1:2], 2'b00};
        end else if (i_stall) begin
            w_pc_next = r_pc;
        end else if (w_pred_taken) begin
            w_pc_next = w_pred_addr;
        end
    end

    // Fetch pc register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= ResetPc;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Update side
    // ------------------------------------------------------------------
    logic [IdxBits-1:0]  w_uidx;
    logic [TagBits-1:0]  w_utag;
    logic [WordSize-1:0] w_utarget;
    logic                w_uhit;
    logic                w_uwe;
    logic [1:0]          w_uctr_new;
    logic [WordSize-1:0] w_utarget_new;

    assign w_uidx    = i_upd_pc[IdxBits+1:2];
    assign w_utag    = i_upd_pc[WordSize-1:IdxBits+2];
    assign w_utarget = {i_upd_target[WordSize-1:2], 2'b00};

    // Training decision: counter step on a hit, allocation on a taken miss.
    always_comb begin
        w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
        w_uwe         = 1'b0;
        w_uctr_new    = r_ctr[w_uidx];
        w_utarget_new = r_target[w_uidx];
        if (i_upd_en) begin
            if (w_uhit) begin
                w_uwe = 1'b1;
                if (i_upd_taken) begin
                    w_utarget_new = w_utarget;
                    if (r_ctr[w_uidx] != CtrMax) begin
                        w_uctr_new = r_ctr[w_uidx] + 2'd1;
                    end
                end else if (r_ctr[w_uidx] != CtrMin) begin
                    w_uctr_new = r_ctr[w_uidx] - 2'd1;
                end
            end else if (i_upd_taken) begin
                // Taken miss replaces whatever occupied this index.
                w_uwe         = 1'b1;
                w_uctr_new    = CtrAlloc;
                w_utarget_new = w_utarget;
            end
        end
    end

    // BTB table write; reset clears the table and blocks any same-cycle update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < BtbEntries; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CtrReset;
            end
        end else if (w_uwe) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= w_utarget_new;
            r_ctr[w_uidx]    <= w_uctr_new;
        end
    end

    // Alignment bits are architecturally ignored.
    logic w_unused;
    assign w_unused = ^{i_upd_pc[1:0], i_upd_target[1:0], i_redirect_pc[1:0]};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_pc         = r_pc;
    assign o_pred_taken = w_pred_taken;
    assign o_pred_addr  = w_pred_addr;
    assign o_pred_pc    = w_pred_pc;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Bench for fetch_pc_btb: directed scenarios followed by random traffic,
// all compared against an address-level model of the BTB and fetch pc.
module tb_fetch_pc_btb;

    localparam int unsigned N = 16;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, upd_en, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] pc, pred_addr, pred_pc;
    logic        pred_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_pc_btb #(
        .WordSize   (32),
        .BtbEntries (N),
        .ResetVector(32'h0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_upd_en     (upd_en),
        .i_upd_pc     (upd_pc),
        .i_upd_target (upd_target),
        .i_upd_taken  (upd_taken),
        .o_pc         (pc),
        .o_pred_taken (pred_taken),
        .o_pred_addr  (pred_addr),
        .o_pred_pc    (pred_pc)
    );

    // Model: each slot remembers the full aligned branch address it holds.
    logic [31:0] m_pc;
    bit          m_valid [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(N));
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return (a / 32'd4) * 32'd4;
    endfunction

    task automatic m_predict(input logic [31:0] a, output bit t, output logic [31:0] tgt);
        int s;
        s   = slot_of(a);
        t   = m_valid[s] && (m_addr[s] == a) && (m_ctr[s] >= 2);
        tgt = t ? m_tgt[s] : 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; model advances, then every output is compared.
    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                        input bit ue, input logic [31:0] upc, input logic [31:0] ut,
                        input bit tk);
        bit          t;
        logic [31:0] tgt, nxt;
        int          k;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        upd_en = ue; upd_pc = upc; upd_target = ut; upd_taken = tk;

        m_predict(m_pc, t, tgt);
        if (r)          nxt = 32'h0;
        else if (rd)    nxt = align(rpc);
        else if (s)     nxt = m_pc;
        else if (t)     nxt = tgt;
        else            nxt = m_pc + 32'd4;

        if (r) begin
            for (int i = 0; i < int'(N); i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
                m_tgt[i]   = 32'h0;
                m_addr[i]  = 32'h0;
            end
        end else if (ue) begin
            k = slot_of(upc);
            if (m_valid[k] && m_addr[k] == align(upc)) begin
                if (tk) begin
                    m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
                    m_tgt[k] = align(ut);
                end else begin
                    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
                end
            end else if (tk) begin
                m_valid[k] = 1'b1;
                m_addr[k]  = align(upc);
                m_tgt[k]   = align(ut);
                m_ctr[k]   = 2;
            end
        end

        @(posedge clk);
        #1;
        m_pc = nxt;
        m_predict(m_pc, t, tgt);
        chk("pc", pc, m_pc);
        chk("pred_taken", {31'h0, pred_taken}, {31'h0, t});
        chk("pred_addr", pred_addr, tgt);
        chk("pred_pc", pred_pc, m_pc + 32'd4);
    endtask

    task automatic run_free();
        step(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic run_upd(input logic [31:0] upc, input logic [31:0] ut, input bit tk);
        step(0, 0, 0, 32'h0, 1, upc, ut, tk);
    endtask

    task automatic run_redir(input logic [31:0] a);
        step(0, 0, 1, a, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] rpc, upc, ut;
        bit          r, s, rd, ue, tk;
        m_pc = 32'h0;

        // Reset state.
        step(1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_pred_pc", pred_pc, 32'h4);
        chk("reset_pred_taken", {31'h0, pred_taken}, 32'h0);

        // Free-running sequential fetch.
        run_free();
        run_free();
        run_free();
        chk("seq_pc_c", pc, 32'hC);

        // Allocate 0x10 -> 0x40 just as fetch arrives at 0x10.
        run_upd(32'h10, 32'h40, 1);
        chk("alloc_pred_taken", {31'h0, pred_taken}, 32'h1);
        chk("alloc_pred_addr", pred_addr, 32'h40);
        run_free();
        chk("alloc_follow", pc, 32'h40);

        // Train to 3, then a not-taken update must not overwrite the target.
        step(0, 0, 1, 32'h10, 1, 32'h10, 32'h40, 1);
        step(0, 1, 0, 32'h0, 1, 32'h10, 32'h99, 0);
        chk("nt_keeps_target", pred_addr, 32'h40);
        step(0, 1, 0, 32'h0, 1, 32'h10, 32'h99, 0);
        step(0, 1, 0, 32'h0, 1, 32'h10, 32'h99, 0);
        chk("ctr0_not_taken", {31'h0, pred_taken}, 32'h0);
        run_free();
        chk("ctr0_fallthrough", pc, 32'h14);

        // Redirect beats stall and drops the low bits; stall holds.
        step(0, 1, 1, 32'h203, 0, 32'h0, 32'h0, 0);
        chk("redir_over_stall", pc, 32'h200);
        step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        chk("stall_hold", pc, 32'h200);

        // Reset mid-run with redirect, stall and an update all active.
        run_upd(32'h20, 32'h60, 1);
        step(1, 1, 1, 32'h300, 1, 32'h0, 32'h80, 1);
        chk("rst_wins_pc", pc, 32'h0);
        chk("rst_ignores_upd", {31'h0, pred_taken}, 32'h0);

        // Aliasing: 0x50 evicts 0x10 from the same slot.
        run_upd(32'h10, 32'h40, 1);
        run_upd(32'h50, 32'h80, 1);
        run_redir(32'h20);
        chk("rst_lost_entry", {31'h0, pred_taken}, 32'h0);
        run_redir(32'h10);
        chk("alias_miss", {31'h0, pred_taken}, 32'h0);
        run_redir(32'h50);
        chk("alias_hit", pred_addr, 32'h80);
        run_free();
        chk("alias_follow", pc, 32'h80);

        // Top-of-memory wrap.
        run_redir(32'hFFFF_FFFC);
        chk("wrap_pred_pc", pred_pc, 32'h0);
        run_free();
        chk("wrap_pc", pc, 32'h0);

        // Random traffic kept in a small window so entries get reused.
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 5) == 0);
            rd  = ($urandom_range(0, 7) == 0) || (m_pc > 32'h400);
            rpc = $urandom_range(0, 32'h1FF);
            ue  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) upc = m_pc | 32'($urandom_range(0, 3));
            else                           upc = $urandom_range(0, 32'h17F);
            ut  = $urandom_range(0, 32'h1FF);
            tk  = ($urandom_range(0, 9) < 7);
            step(r, s, rd, rpc, ue, upc, ut, tk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
